// File: rtl/axi4_stream_initiator_type_1.sv
`default_nettype none
// ============================================================================
// axi4_stream_initiator_type_1 : deterministic AXI4-Stream source with a
// stream/frame/packet/transfer hierarchy and optional active/pause windows.
// Revision 1.0
// ============================================================================
module axi4_stream_initiator_type_1 #(
  parameter int unsigned AxiStreamInitiatorIfTDataWidth         = 32,
  parameter int unsigned AxiStreamInitiatorIfTIdWidth           = 4,
  parameter int unsigned AxiStreamInitiatorIfTDestWidth         = 4,
  parameter int unsigned AxiStreamInitiatorIfTId                = 0,
  parameter int unsigned AxiStreamInitiatorIfTDest              = 0,
  parameter string       AxiStreamInitiatorIfInitiatorMode      = "LOOP",
  parameter int unsigned AxiStreamInitiatorIfCyclesActive       = 0,
  parameter int unsigned AxiStreamInitiatorIfCyclesPause        = 0,
  parameter int unsigned AxiStreamInitiatorIfTransfersPerPacket = 1,
  parameter int unsigned AxiStreamInitiatorIfPacketsPerFrame    = 1,
  parameter int unsigned AxiStreamInitiatorIfFramesPerStream    = 1,
  parameter string       AxiStreamInitiatorIfTlastFlagTrigger   = "NONE"
) (
  input  logic                                      clk_m_axis_i,
  input  logic                                      rst_m_axis_ni,
  output logic                                      m_axis_tvalid_o,
  input  logic                                      m_axis_tready_i,
  output logic [AxiStreamInitiatorIfTDataWidth-1:0] m_axis_tdata_o,
  output logic                                      m_axis_tlast_o,
  output logic [AxiStreamInitiatorIfTIdWidth-1:0]   m_axis_tid_o,
  output logic [AxiStreamInitiatorIfTDestWidth-1:0] m_axis_tdest_o,
  output logic                                      m_axis_tdone_o
);

  localparam int unsigned DW  = AxiStreamInitiatorIfTDataWidth;
  localparam int unsigned IW  = AxiStreamInitiatorIfTIdWidth;
  localparam int unsigned TPP = (AxiStreamInitiatorIfTransfersPerPacket == 0) ? 1 : AxiStreamInitiatorIfTransfersPerPacket;
  localparam int unsigned PPF = (AxiStreamInitiatorIfPacketsPerFrame == 0) ? 1 : AxiStreamInitiatorIfPacketsPerFrame;
  localparam int unsigned FPS = (AxiStreamInitiatorIfFramesPerStream == 0) ? 1 : AxiStreamInitiatorIfFramesPerStream;

  localparam logic [DW-1:0] INIT = (DW <= 8)  ? DW'(32'h0000_00A0) :
                                   (DW <= 16) ? DW'(32'h0000_0A00) : DW'(32'hABC0_0B00);
  localparam logic [DW-1:0] STEP = (DW <= 8)  ? DW'(32'h0000_0001) :
                                   (DW <= 16) ? DW'(32'h0000_0101) : DW'(32'h0001_0001);

  localparam bit IS_SINGLE     = (AxiStreamInitiatorIfInitiatorMode == "SINGLE");
  localparam bit USE_PAUSE     = (AxiStreamInitiatorIfCyclesPause != 0);
  localparam bit TRIG_TRANSFER = (AxiStreamInitiatorIfTlastFlagTrigger == "TRANSFER");
  localparam bit TRIG_PACKET   = (AxiStreamInitiatorIfTlastFlagTrigger == "PACKET");
  localparam bit TRIG_FRAME    = (AxiStreamInitiatorIfTlastFlagTrigger == "FRAME");
  localparam bit TRIG_STREAM   = (AxiStreamInitiatorIfTlastFlagTrigger == "STREAM");

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   active_cnt_q, active_cnt_d;
  logic [31:0]   pause_cnt_q, pause_cnt_d;
  logic [31:0]   beat_cnt_q, beat_cnt_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;
  logic [31:0]   frm_cnt_q, frm_cnt_d;
  logic [DW-1:0] tdata_q, tdata_d;
  logic [IW-1:0] tid_q, tid_d;

  logic handshake;
  logic last_of_packet;
  logic last_of_frame;
  logic last_of_stream;
  logic window_end;

  // Down-counters hold the number of beats/packets/frames still to go, so "1" marks the last one.
  assign last_of_packet = (beat_cnt_q == 32'd1);
  assign last_of_frame  = last_of_packet && (pkt_cnt_q == 32'd1);
  assign last_of_stream = last_of_frame && (frm_cnt_q == 32'd1);
  assign handshake      = (state_q == ST_ACTIVE) && m_axis_tready_i;
  // The handshake that drains the window's last eligible cycle ends it; a stall defers the pause.
  assign window_end     = USE_PAUSE && (active_cnt_q <= 32'd1);

  always_ff @(posedge clk_m_axis_i) begin
    if (!rst_m_axis_ni) begin
      state_q      <= ST_RESET;
      active_cnt_q <= 32'(AxiStreamInitiatorIfCyclesActive);
      pause_cnt_q  <= '0;
      beat_cnt_q   <= 32'(TPP);
      pkt_cnt_q    <= 32'(PPF);
      frm_cnt_q    <= 32'(FPS);
      tdata_q      <= INIT;
      tid_q        <= IW'(AxiStreamInitiatorIfTId);
    end else begin
      state_q      <= state_d;
      active_cnt_q <= active_cnt_d;
      pause_cnt_q  <= pause_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      tdata_q      <= tdata_d;
      tid_q        <= tid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    active_cnt_d = active_cnt_q;
    pause_cnt_d  = pause_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    tdata_d      = tdata_q;
    tid_d        = tid_q;

    case (state_q)
      ST_RESET: begin
        state_d      = ST_ACTIVE;
        active_cnt_d = 32'(AxiStreamInitiatorIfCyclesActive);
      end
      ST_ACTIVE: begin
        if (active_cnt_q != 32'd0) active_cnt_d = active_cnt_q - 32'd1;
        if (handshake) begin
          if (IS_SINGLE && last_of_stream) begin
            state_d = ST_DONE;
          end else if (window_end) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = 32'(AxiStreamInitiatorIfCyclesPause - 1);
          end
        end
      end
      ST_PAUSE: begin
        if (pause_cnt_q == 32'd0) begin
          state_d      = ST_ACTIVE;
          active_cnt_d = 32'(AxiStreamInitiatorIfCyclesActive);
        end else begin
          pause_cnt_d = pause_cnt_q - 32'd1;
        end
      end
      default: state_d = ST_DONE;
    endcase

    if (handshake) begin
      tdata_d = tdata_q + STEP;
      if (!last_of_packet) begin
        beat_cnt_d = beat_cnt_q - 32'd1;
      end else begin
        beat_cnt_d = 32'(TPP);
        if (pkt_cnt_q != 32'd1) begin
          pkt_cnt_d = pkt_cnt_q - 32'd1;
        end else begin
          pkt_cnt_d = 32'(PPF);
          if (frm_cnt_q != 32'd1) begin
            frm_cnt_d = frm_cnt_q - 32'd1;
          end else begin
            frm_cnt_d = 32'(FPS);
            tid_d     = tid_q + IW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    m_axis_tvalid_o = (state_q == ST_ACTIVE);
    m_axis_tdone_o  = (state_q == ST_DONE);
    m_axis_tdata_o  = tdata_q;
    m_axis_tid_o    = tid_q;
    m_axis_tdest_o  = AxiStreamInitiatorIfTDestWidth'(AxiStreamInitiatorIfTDest);
    if (TRIG_TRANSFER)    m_axis_tlast_o = 1'b1;
    else if (TRIG_PACKET) m_axis_tlast_o = last_of_packet;
    else if (TRIG_FRAME)  m_axis_tlast_o = last_of_frame;
    else if (TRIG_STREAM) m_axis_tlast_o = last_of_stream;
    else                  m_axis_tlast_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_initiator_type_1.sv
`default_nettype none
// ============================================================================
// tb_axi4_stream_initiator_type_1 : directed checks of three initiator
// configurations (LOOP/PACKET, SINGLE/STREAM, active-pause windows).
// Revision 1.0
// ============================================================================
module tb_axi4_stream_initiator_type_1;

  localparam logic [31:0] INIT = 32'hABC0_0B00;
  localparam logic [31:0] STEP = 32'h0001_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;

  logic        vld_a, last_a, done_a;
  logic [31:0] data_a;
  logic [3:0]  tid_a, dest_a;
  logic        vld_b, last_b, done_b;
  logic [31:0] data_b;
  logic [3:0]  tid_b, dest_b;
  logic        vld_c, last_c, done_c;
  logic [31:0] data_c;
  logic [3:0]  tid_c, dest_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTransfersPerPacket(2),
    .AxiStreamInitiatorIfPacketsPerFrame(2),
    .AxiStreamInitiatorIfFramesPerStream(1),
    .AxiStreamInitiatorIfTlastFlagTrigger("PACKET")
  ) dut_a (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n),
    .m_axis_tvalid_o(vld_a), .m_axis_tready_i(rdy_a), .m_axis_tdata_o(data_a),
    .m_axis_tlast_o(last_a), .m_axis_tid_o(tid_a), .m_axis_tdest_o(dest_a),
    .m_axis_tdone_o(done_a)
  );

  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfTDest(5),
    .AxiStreamInitiatorIfInitiatorMode("SINGLE"),
    .AxiStreamInitiatorIfTransfersPerPacket(3),
    .AxiStreamInitiatorIfTlastFlagTrigger("STREAM")
  ) dut_b (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n),
    .m_axis_tvalid_o(vld_b), .m_axis_tready_i(rdy_b), .m_axis_tdata_o(data_b),
    .m_axis_tlast_o(last_b), .m_axis_tid_o(tid_b), .m_axis_tdest_o(dest_b),
    .m_axis_tdone_o(done_b)
  );

  axi4_stream_initiator_type_1 #(
    .AxiStreamInitiatorIfCyclesActive(3),
    .AxiStreamInitiatorIfCyclesPause(2),
    .AxiStreamInitiatorIfTlastFlagTrigger("TRANSFER")
  ) dut_c (
    .clk_m_axis_i(clk), .rst_m_axis_ni(rst_n),
    .m_axis_tvalid_o(vld_c), .m_axis_tready_i(rdy_c), .m_axis_tdata_o(data_c),
    .m_axis_tlast_o(last_c), .m_axis_tid_o(tid_c), .m_axis_tdest_o(dest_c),
    .m_axis_tdone_o(done_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state of the LOOP/PACKET instance
    rdy_a = 1'b1;
    do_reset();
    check("a_rst_tvalid", 64'(vld_a), 64'd0);
    check("a_rst_tdata", 64'(data_a), 64'(INIT));
    check("a_rst_tid", 64'(tid_a), 64'd0);
    check("a_rst_tlast", 64'(last_a), 64'd0);
    check("a_rst_tdone", 64'(done_a), 64'd0);
    check("b_rst_tdest", 64'(dest_b), 64'd5);
    tick();

    // Five beats: packet tlast on odd beats, tid steps after the 4-beat stream
    for (int i = 0; i < 5; i++) begin
      check($sformatf("a_beat%0d_tvalid", i), 64'(vld_a), 64'd1);
      check($sformatf("a_beat%0d_tdata", i), 64'(data_a), 64'(INIT + STEP * i));
      check($sformatf("a_beat%0d_tlast", i), 64'(last_a), 64'(i % 2));
      check($sformatf("a_beat%0d_tid", i), 64'(tid_a), 64'(i / 4));
      tick();
    end

    // Stall on beat 5 (last of packet): everything holds
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("a_stall%0d_tvalid", i), 64'(vld_a), 64'd1);
      check($sformatf("a_stall%0d_tdata", i), 64'(data_a), 64'(INIT + STEP * 5));
      check($sformatf("a_stall%0d_tlast", i), 64'(last_a), 64'd1);
      check($sformatf("a_stall%0d_tid", i), 64'(tid_a), 64'd1);
    end
    rdy_a = 1'b1;
    tick();
    check("a_after_stall_tdata", 64'(data_a), 64'(INIT + STEP * 6));
    check("a_after_stall_tlast", 64'(last_a), 64'd0);

    // Reset while stalled restarts the stream
    rdy_a = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("a_midrst_tvalid", 64'(vld_a), 64'd0);
    check("a_midrst_tdata", 64'(data_a), 64'(INIT));
    check("a_midrst_tid", 64'(tid_a), 64'd0);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    tick();
    check("a_restart_tvalid", 64'(vld_a), 64'd1);
    check("a_restart_tdata0", 64'(data_a), 64'(INIT));
    tick();
    check("a_restart_tdata1", 64'(data_a), 64'(INIT + STEP));
    check("a_restart_tlast1", 64'(last_a), 64'd1);
    rdy_a = 1'b0;

    // SINGLE mode, 3-beat stream
    rdy_b = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b_beat%0d_tvalid", i), 64'(vld_b), 64'd1);
      check($sformatf("b_beat%0d_tdata", i), 64'(data_b), 64'(INIT + STEP * i));
      check($sformatf("b_beat%0d_tlast", i), 64'(last_b), 64'(i == 2));
      check($sformatf("b_beat%0d_tdone", i), 64'(done_b), 64'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_done%0d_tvalid", i), 64'(vld_b), 64'd0);
      check($sformatf("b_done%0d_tdone", i), 64'(done_b), 64'd1);
      check($sformatf("b_done%0d_tdata", i), 64'(data_b), 64'(INIT + STEP * 3));
      tick();
    end
    rdy_b = 1'b0;

    // Active/pause windows: 3 valid, 2 idle
    rdy_c = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("c_win%0d_tvalid", i), 64'(vld_c), 64'((i % 5) < 3));
      if ((i % 5) < 3) check($sformatf("c_win%0d_tlast", i), 64'(last_c), 64'd1);
      tick();
    end
    // Third window: stall on its last eligible cycle defers the pause
    check("c_w3_c0_tvalid", 64'(vld_c), 64'd1);
    tick();
    check("c_w3_c1_tvalid", 64'(vld_c), 64'd1);
    tick();
    check("c_w3_c2_tvalid", 64'(vld_c), 64'd1);
    rdy_c = 1'b0;
    tick();
    check("c_defer0_tvalid", 64'(vld_c), 64'd1);
    tick();
    check("c_defer1_tvalid", 64'(vld_c), 64'd1);
    check("c_defer1_tdata", 64'(data_c), 64'(INIT + STEP * 8));
    rdy_c = 1'b1;
    tick();
    check("c_pause_tvalid", 64'(vld_c), 64'd0);
    check("c_pause_tdata", 64'(data_c), 64'(INIT + STEP * 9));
    check("c_pause_tdone", 64'(done_c), 64'd0);
    tick();
    check("c_pause2_tvalid", 64'(vld_c), 64'd0);
    tick();
    check("c_resume_tvalid", 64'(vld_c), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
